// File: rtl/cp_pkg.sv
// Shared types and default constants for the charge-pump comparator readout.
package cp_pkg;

    localparam int CP_CNT_W   = 8;
    localparam int CP_TIMEOUT = 200;
    localparam int CP_FILT_N  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECHG  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } cp_state_e;

endpackage

// File: rtl/cp_sync2.sv
// Two-flop synchroniser bringing the asynchronous comparator output into clk.
module cp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cp_readout.sv
// Charge-pump readout: counts cycles from end of precharge to comparator trip.
// Optional trip glitch filter enabled by defining CP_READOUT_FILTER_EN.
module cp_readout
    import cp_pkg::*;
#(
    parameter int CNT_W   = CP_CNT_W,
    parameter int TIMEOUT = CP_TIMEOUT,
    parameter int FILT_N  = CP_FILT_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preChrg,
    input  logic             cmp,
    input  logic             ack,
    output logic [CNT_W-1:0] code,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    // Elaboration-time guards: the counter must never need to wrap.
    if (TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("cp_readout: TIMEOUT does not fit in CNT_W bits");
    end
    if (FILT_N < 1) begin : g_bad_filt
        $error("cp_readout: FILT_N must be at least 1");
    end

    logic cmp_s;
    logic cmp_f;

    cp_sync2 u_sync (
        .clk (clk),
        .rst (reset),
        .d_i (cmp),
        .q_o (cmp_s)
    );

`ifdef CP_READOUT_FILTER_EN
    localparam int RUN_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_N - 1);

    logic [RUN_W-1:0] run_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= '0;
        end else if (!cmp_s) begin
            run_q <= '0;
        end else if (run_q != RUN_MAX) begin
            run_q <= run_q + RUN_W'(1);
        end
    end

    assign cmp_f = cmp_s && (run_q == RUN_MAX);
`else
    assign cmp_f = cmp_s;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    cp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             tout_q, tout_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        tout_d  = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (preChrg) state_d = ST_PRECHG;
            end
            ST_PRECHG: begin
                cnt_d = '0;
                if (!preChrg) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                // Trip outranks timeout, so a trip on the last count reports code=TIMEOUT.
                if (preChrg) begin
                    state_d = ST_PRECHG;
                    cnt_d   = '0;
                end else if (cmp_f) begin
                    state_d = ST_DONE;
                    code_d  = cnt_q;
                    tout_d  = 1'b0;
                    valid_d = 1'b1;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_DONE;
                    code_d  = TIMEOUT_C;
                    tout_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    tout_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_PRECHG) || (state_d == ST_MEASURE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign timeout = tout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cp_readout.sv
// Directed bench for cp_readout; expectations follow the CP_READOUT_FILTER_EN build setting.
module tb_cp_readout;

`ifdef CP_READOUT_FILTER_EN
    localparam int FX = 2;
    localparam bit FILT = 1'b1;
`else
    localparam int FX = 0;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       preChrg;
    logic       cmp;
    logic       ack;
    logic [7:0] code;
    logic       valid;
    logic       timeout;
    logic       busy;

    int total = 0;
    int bad   = 0;

    cp_readout #(.CNT_W(8), .TIMEOUT(200), .FILT_N(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .preChrg (preChrg),
        .cmp     (cmp),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Leaves the bench just after edge E0 (the edge that enters MEASURE).
    task automatic start_meas(input int n_pre);
        preChrg = 1'b1;
        step(n_pre);
        preChrg = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; preChrg = 1'b0; cmp = 1'b0; ack = 1'b0;
        step(2);
        check("rst_code", 32'(code), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_tout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step(1);

        // Basic trip: cmp rises just after E0+10
        start_meas(12);
        check("e0_busy", 32'(busy), 1);
        check("e0_valid", 32'(valid), 0);
        step(10);
        cmp = 1'b1;
        step(2 + FX);
        check("trip_early", 32'(valid), 0);
        step(1);
        check("trip_valid", 32'(valid), 1);
        check("trip_code", 32'(code), 12 + FX);
        check("trip_tout", 32'(timeout), 0);
        check("trip_busy", 32'(busy), 0);
        step(1);
        check("trip_hold", 32'(valid), 1);
        ack = 1'b1; cmp = 1'b0;
        step(1);
        ack = 1'b0;
        check("ack_valid", 32'(valid), 0);
        check("ack_busy", 32'(busy), 0);

        // Timeout: cmp stays low
        start_meas(6);
        step(200);
        check("to_before", 32'(valid), 0);
        step(1);
        check("to_valid", 32'(valid), 1);
        check("to_code", 32'(code), 200);
        check("to_tout", 32'(timeout), 1);
        step(50);
        check("to_hold_v", 32'(valid), 1);
        check("to_hold_t", 32'(timeout), 1);
        check("to_hold_c", 32'(code), 200);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("to_ack_v", 32'(valid), 0);
        check("to_ack_t", 32'(timeout), 0);

        // Abort at count 5, then a clean measurement
        start_meas(5);
        step(5);
        preChrg = 1'b1;
        step(1);
        check("abort_busy", 32'(busy), 1);
        check("abort_valid", 32'(valid), 0);
        step(3);
        check("abort_valid2", 32'(valid), 0);
        preChrg = 1'b0;
        step(1);
        step(3);
        cmp = 1'b1;
        step(2 + FX);
        check("re_early", 32'(valid), 0);
        step(1);
        check("re_valid", 32'(valid), 1);
        check("re_code", 32'(code), 5 + FX);

        // preChrg pulse while DONE is ignored
        preChrg = 1'b1;
        step(2);
        preChrg = 1'b0;
        step(2);
        check("bp_code", 32'(code), 5 + FX);
        check("bp_valid", 32'(valid), 1);
        check("bp_busy", 32'(busy), 0);

        // ack with preChrg high: IDLE first, PRECHG one edge later
        ack = 1'b1; preChrg = 1'b1; cmp = 1'b0;
        step(1);
        ack = 1'b0;
        check("ackp_valid", 32'(valid), 0);
        check("ackp_busy0", 32'(busy), 0);
        step(1);
        check("ackp_busy1", 32'(busy), 1);

        // Reset mid-MEASURE clears outputs immediately
        preChrg = 1'b0;
        step(1);
        step(3);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mr_code", 32'(code), 0);
        check("mr_valid", 32'(valid), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_tout", 32'(timeout), 0);
        #1;
        reset = 1'b0;
        step(2);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_v", 32'(valid), 0);

        // Comparator already high through PRECHG: code 0 at E0+1
        cmp = 1'b1;
        start_meas(6);
        check("early_e0", 32'(valid), 0);
        step(1);
        check("early_valid", 32'(valid), 1);
        check("early_code", 32'(code), 0);
        check("early_tout", 32'(timeout), 0);
        ack = 1'b1; cmp = 1'b0;
        step(1);
        ack = 1'b0;
        check("early_ack", 32'(valid), 0);

        // Two-cycle cmp pulse starting just after E0+3
        start_meas(6);
        step(3);
        cmp = 1'b1;
        step(2);
        cmp = 1'b0;
        step(1);
        if (FILT) begin
            step(10);
            check("glitch_valid", 32'(valid), 0);
            check("glitch_busy", 32'(busy), 1);
            reset = 1'b1;
            #2;
            reset = 1'b0;
            step(1);
        end else begin
            check("glitch_valid", 32'(valid), 1);
            check("glitch_code", 32'(code), 5);
            ack = 1'b1;
            step(1);
            ack = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
